// File: rtl/pulse_rate_meter_pkg.sv
// Shared types and constants for the pulse rate meter.
// Holds the FSM state enum and the default gate length.
package pulse_rate_meter_pkg;

  // 250 ms at 50 MHz; also used by the 250 ms tick generator.
  localparam int unsigned T_GATE_DEFAULT = 12_500_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_rate_meter_sync.sv
// pulse_sync: 2-flop synchronizer, optional debounce, edge detect.
// Ports: clk, rst_n, pulse_i (async), edge_o (1-cycle strobe).
// Debounce is built when PULSE_RATE_METER_DEBOUNCE_EN is defined.
module pulse_sync #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_i,
  output logic edge_o
);

  logic s1_q, s2_q;
  logic prev_q, edge_q;
  logic lvl;

  if (DEB_CYC < 1) begin : g_bad_deb
    $error("DEB_CYC must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pulse_i;
      s2_q <= s1_q;
    end
  end

`ifdef PULSE_RATE_METER_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYC + 1);

  logic          filt_q, filt_d;
  logic [DW-1:0] stab_q, stab_d;

  // Output follows s2 only after DEB_CYC equal samples in a row.
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    if (s2_q != filt_q) begin
      if (stab_q == DW'(DEB_CYC - 1)) begin
        filt_d = s2_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else begin
      filt_q <= filt_d;
      stab_q <= stab_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      prev_q <= lvl;
      edge_q <= lvl & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts pulse_in rising edges over a T_GATE-cycle gate window.
// Ports: clk, rst_n, start, continuous, pulse_in -> rate,
//   rate_valid, overflow, busy. Macro: PULSE_RATE_METER_DEBOUNCE_EN.
module pulse_rate_meter
  import pulse_rate_meter_pkg::*;
#(
  parameter int unsigned T_GATE  = T_GATE_DEFAULT,
  parameter int          CNT_W   = 6,
  parameter int          DEB_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = (T_GATE > 1) ? $clog2(T_GATE) : 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             eovf_q, eovf_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             ovf_q, ovf_d;
  logic             rv_q, rv_d;
  logic             edge_s;
  logic [CNT_W-1:0] win_cnt;
  logic             win_ovf;

  pulse_sync #(.DEB_CYC(DEB_CYC)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pulse_i(pulse_in),
    .edge_o (edge_s)
  );

  // Window totals including this cycle's edge, so the last
  // gate cycle's edge lands in the report.
  always_comb begin
    win_cnt = ecnt_q;
    win_ovf = eovf_q;
    if (edge_s) begin
      if (ecnt_q == CMAX) begin
        win_ovf = 1'b1;
      end else begin
        win_cnt = ecnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    ecnt_d  = ecnt_q;
    eovf_d  = eovf_q;
    rate_d  = rate_q;
    ovf_d   = ovf_q;
    rv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GATE;
          gcnt_d  = '0;
          ecnt_d  = '0;
          eovf_d  = 1'b0;
        end
      end
      GATE: begin
        ecnt_d = win_cnt;
        eovf_d = win_ovf;
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == GW'(T_GATE - 1)) begin
          state_d = REPORT;
          rate_d  = win_cnt;
          ovf_d   = win_ovf;
          rv_d    = 1'b1;
        end
      end
      REPORT: begin
        if (continuous) begin
          state_d = GATE;
          gcnt_d  = '0;
          ecnt_d  = '0;
          eovf_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      ecnt_q  <= '0;
      eovf_q  <= 1'b0;
      rate_q  <= '0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      ecnt_q  <= ecnt_d;
      eovf_q  <= eovf_d;
      rate_q  <= rate_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
    end
  end

  assign rate       = rate_q;
  assign overflow   = ovf_q;
  assign rate_valid = rv_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Randomized and directed bench for pulse_rate_meter.
// Expected results come from an edge-timing model of the window.
module tb_pulse_rate_meter;

  localparam int T    = 200;
  localparam int W    = 6;
  localparam int DEB  = 4;
  localparam int MAXC = 700;
  localparam int CMAX = (1 << W) - 1;
`ifdef PULSE_RATE_METER_DEBOUNCE_EN
  localparam int LAT    = 3 + DEB;
  localparam int MINSEG = DEB + 1;
  localparam int SP     = 2 * (DEB + 1);
`else
  localparam int LAT    = 3;
  localparam int MINSEG = 1;
  localparam int SP     = 8;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         pulse_in = 1'b0;
  logic [W-1:0] rate;
  logic         rate_valid;
  logic         overflow;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  bit pin_a [MAXC];
  bit st_a  [MAXC];
  bit cont_a[MAXC];
  bit rst_a [MAXC];
  int rv_a  [MAXC];
  int rate_a[MAXC];
  int ovf_a [MAXC];
  int busy_a[MAXC];

  pulse_rate_meter #(
    .T_GATE (T),
    .CNT_W  (W),
    .DEB_CYC(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .continuous(continuous),
    .pulse_in  (pulse_in),
    .rate      (rate),
    .rate_valid(rate_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      pin_a[c]  = 1'b0;
      st_a[c]   = 1'b0;
      cont_a[c] = 1'b0;
      rst_a[c]  = 1'b0;
    end
  endtask

  task automatic put_pulse(input int r);
    for (int k = 0; k < MINSEG; k++) pin_a[r + k] = 1'b1;
  endtask

  // Iteration c samples outputs of cycle c, then drives cycle c inputs.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rv_a[c]    = int'(rate_valid);
      rate_a[c]  = int'(rate);
      ovf_a[c]   = int'(overflow);
      busy_a[c]  = int'(busy);
      rst_n      = ~rst_a[c];
      start      = st_a[c];
      continuous = cont_a[c];
      pulse_in   = pin_a[c];
    end
    rst_n      = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    pulse_in   = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  function automatic bit rise(input int r);
    if (r == 0) return pin_a[0];
    return pin_a[r] && !pin_a[r-1];
  endfunction

  // Model: a rise driven in cycle r is seen by the counter in
  // cycle r+LAT; windows follow the first start, back-to-back
  // while continuous is high in the report cycle.
  task automatic check_run(input int n, input string tag);
    bit exp_rv[MAXC];
    int cyc, ws, we, rep, cnt, spur, last, lrep;
    bit more;
    cyc = -1;
    last = -1;
    lrep = -1;
    for (int c = 0; c < n; c++) begin
      if (st_a[c]) begin
        cyc = c;
        break;
      end
    end
    more = (cyc >= 0);
    while (more) begin
      ws = cyc + 1;
      we = cyc + T;
      rep = cyc + T + 1;
      if (rep + 1 >= n) begin
        chk({tag, "_horizon"}, rep, n - 2);
        break;
      end
      cnt = 0;
      for (int r = 0; r < n; r++)
        if (rise(r) && r + LAT >= ws && r + LAT <= we) cnt++;
      exp_rv[rep] = 1'b1;
      chk({tag, "_rv"}, rv_a[rep], 1);
      chk({tag, "_rate"}, rate_a[rep], (cnt > CMAX) ? CMAX : cnt);
      chk({tag, "_ovf"}, ovf_a[rep], (cnt > CMAX) ? 1 : 0);
      chk({tag, "_busy_gate"}, busy_a[ws], 1);
      chk({tag, "_busy_rep"}, busy_a[rep], 1);
      last = (cnt > CMAX) ? CMAX : cnt;
      lrep = rep;
      if (cont_a[rep]) begin
        cyc = rep;
      end else begin
        more = 1'b0;
        chk({tag, "_busy_idle"}, busy_a[rep + 1], 0);
      end
    end
    spur = 0;
    for (int c = 0; c < n; c++)
      if (rv_a[c] != 0 && !exp_rv[c]) spur++;
    chk({tag, "_spurious"}, spur, 0);
    if (last >= 0 && lrep < n - 1)
      chk({tag, "_hold"}, rate_a[n-1], last);
  endtask

  initial begin
    int s, c, lvl, len, nv, nb;

    // Reset held, then released with no start.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rate", int'(rate), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rv", int'(rate_valid), 0);
    rst_n = 1'b1;
    clear_stim();
    run(60);
    chk("idle_rate", rate_a[59], 0);
    chk("idle_ovf", ovf_a[59], 0);
    chk("idle_busy", busy_a[59], 0);
    check_run(60, "idle");

    // Ten spaced pulses inside one window.
    clear_stim();
    st_a[0] = 1'b1;
    for (int i = 0; i < 10; i++) put_pulse(10 + SP * i);
    run(T + 40);
    chk("ten_rv", rv_a[T + 1], 1);
    chk("ten_rate", rate_a[T + 1], 10);
    chk("ten_ovf", ovf_a[T + 1], 0);
    chk("ten_busy", busy_a[T + 2], 0);
    check_run(T + 40, "ten");

    // Fast toggling drives the counter into saturation.
    clear_stim();
    st_a[0] = 1'b1;
    for (int k = 0; k < T; k++) pin_a[k] = ((k / MINSEG) % 2) == 1;
    run(T + 40);
`ifndef PULSE_RATE_METER_DEBOUNCE_EN
    chk("sat_rate", rate_a[T + 1], CMAX);
    chk("sat_ovf", ovf_a[T + 1], 1);
`endif
    check_run(T + 40, "sat");

    // Continuous windows, five edges each, then stop.
    clear_stim();
    st_a[0] = 1'b1;
    for (int k = 0; k < 500; k++) cont_a[k] = 1'b1;
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 5; i++) put_pulse(w * (T + 1) + 20 + SP * i);
    run(650);
    chk("cont_rv1", rv_a[201], 1);
    chk("cont_rv2", rv_a[402], 1);
    chk("cont_rv3", rv_a[603], 1);
    chk("cont_r3", rate_a[603], 5);
    chk("cont_idle", busy_a[605], 0);
    check_run(650, "cont");

    // Reset in the middle of a window.
    clear_stim();
    st_a[0] = 1'b1;
    for (int i = 0; i < 7; i++) put_pulse(10 + SP * i);
    for (int k = 100; k < 103; k++) rst_a[k] = 1'b1;
    run(T + 60);
    chk("mid_busy_pre", busy_a[99], 1);
    chk("mid_rate", rate_a[101], 0);
    chk("mid_ovf", ovf_a[101], 0);
    chk("mid_busy", busy_a[101], 0);
    nv = 0;
    nb = 0;
    for (int k = 0; k < T + 60; k++) begin
      nv += rv_a[k];
      if (k > 101) nb += busy_a[k];
    end
    chk("mid_no_rv", nv, 0);
    chk("mid_busy_after", nb, 0);

    // Edge arrival just outside / inside the window ends.
    for (int b = 0; b < 4; b++) begin
      int land;
      int want;
      clear_stim();
      st_a[20] = 1'b1;
      case (b)
        0: land = 20;
        1: land = 21;
        2: land = 20 + T;
        default: land = 21 + T;
      endcase
      want = (b == 1 || b == 2) ? 1 : 0;
      put_pulse(land - LAT);
      run(T + 60);
      chk($sformatf("bnd%0d", b), rate_a[T + 21], want);
      check_run(T + 60, $sformatf("bnd%0d", b));
    end

    // Two-cycle glitch.
    clear_stim();
    st_a[0] = 1'b1;
    pin_a[50] = 1'b1;
    pin_a[51] = 1'b1;
    run(T + 40);
`ifdef PULSE_RATE_METER_DEBOUNCE_EN
    chk("glitch", rate_a[T + 1], 0);
`else
    chk("glitch", rate_a[T + 1], 1);
`endif

    // Random streams, with start/continuous noise mid-window.
    for (int it = 0; it < 5; it++) begin
      clear_stim();
      s = $urandom_range(0, 10);
      st_a[s] = 1'b1;
      st_a[s + 1 + $urandom_range(0, T - 1)] = 1'b1;
      st_a[s + T + 1] = 1'b1;
      for (int k = s + 1; k <= s + T; k++)
        cont_a[k] = 1'($urandom_range(0, 1));
      c = 0;
      lvl = 0;
      while (c < s + T + 5) begin
        len = MINSEG + $urandom_range(0, 2 * it + 1);
        for (int k = 0; k < len; k++) pin_a[c + k] = (lvl != 0);
        c += len;
        lvl ^= 1;
      end
      run(s + T + 40);
      check_run(s + T + 40, $sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
